sddac_ctrl: RTL and testbench

Sample-rate controller that feeds the `sddac` sigma-delta modulator. It generates the audio sample strobe from the system clock and buffers producer samples in a small FIFO with a valid/ready handshake. On each strobe it pops one sample, applies a click-free mute gain ramp, and drives the registered 16-bit word onto the modulator's `sig_in`. It replaces ad-hoc strobe-and-latch logic in front of the DAC and reports FIFO underruns.

---
 rtl/sddac_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_sddac_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sddac_ctrl.sv
// sddac_ctrl: sample-rate strobe, sample FIFO and mute gain stage in front of
// the sddac sigma-delta modulator.
// Build option: define SDDAC_CTRL_RAMP_EN to get the click-free gain ramp
// (OFF/RAMP_UP/ON/RAMP_DOWN). Without it the gain switches hard between
// 0 and 256 (OFF/ON only) and RAMP_STEP has no effect.
module sddac_ctrl #(
    parameter int CLK_DIV    = 1000,
    parameter int FIFO_DEPTH = 4,
    parameter int RAMP_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        mute,
    input  logic        clr_underrun,
    output logic        sample_tick,
    output logic [15:0] sig_out,
    output logic [7:0]  underrun_cnt
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
    localparam logic [8:0]       G_FULL   = 9'd256;

    // Reject illegal parameter sets at elaboration time.
    generate
        if (CLK_DIV < 4 || FIFO_DEPTH < 2 || FIFO_DEPTH > 64 ||
            (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
            RAMP_STEP < 1 || (256 % RAMP_STEP) != 0) begin : g_bad_params
            $error("sddac_ctrl: illegal CLK_DIV/FIFO_DEPTH/RAMP_STEP");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_ON        = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } state_t;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [15:0]      fifo_mem [FIFO_DEPTH];
    state_t           state_q, state_d;
    logic [8:0]       g_q, g_d;
    logic signed [15:0] sample_q, sample_d;
    logic [15:0]      sig_q, sig_d;
    logic [7:0]       under_q, under_d;

    logic        tick, full, empty, push, pop_req, pop;
    logic [15:0] head;
    logic signed [23:0] product;

    assign tick        = (cnt_q == CNT_LAST);
    assign full        = (occ_q == OCC_FULL);
    assign empty       = (occ_q == '0);
    assign s_ready     = ~full;
    assign push        = s_valid & ~full;
    assign pop         = pop_req & ~empty;
    assign head        = empty ? 16'h0000 : fifo_mem[rd_ptr_q];
    assign sample_tick = tick;
    assign sig_out     = sig_q;
    assign underrun_cnt = under_q;

    // Free-running sample-period counter, wraps in the tick cycle.
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    // FIFO pointer and occupancy update; the full flag only depends on the
    // registered occupancy, so a same-cycle pop never frees a slot early.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

`ifdef SDDAC_CTRL_RAMP_EN
    logic [9:0] g_sum;
    logic [8:0] g_up, g_dn;

    // Saturating gain step up/down for the ramp states.
    always_comb begin
        g_sum = {1'b0, g_q} + 10'(RAMP_STEP);
        g_up  = (g_sum >= 10'd256) ? G_FULL : g_sum[8:0];
        g_dn  = (g_q <= 9'(RAMP_STEP)) ? 9'd0 : g_q - 9'(RAMP_STEP);
    end
`endif

    // Mute state machine: next state, gain and popped sample, evaluated on ticks.
    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        sample_d = sample_q;
        pop_req  = 1'b0;
        if (tick) begin
            case (state_q)
                ST_OFF: begin
                    // Clearing the sample here keeps the first unmuted tick silent.
                    sample_d = '0;
                    g_d      = '0;
`ifdef SDDAC_CTRL_RAMP_EN
                    if (!mute) state_d = ST_RAMP_UP;
`else
                    if (!mute) begin
                        state_d = ST_ON;
                        g_d     = G_FULL;
                    end
`endif
                end
`ifdef SDDAC_CTRL_RAMP_EN
                ST_RAMP_UP: begin
                    pop_req  = 1'b1;
                    sample_d = head;
                    g_d      = g_up;
                    if (mute)                 state_d = ST_RAMP_DOWN;
                    else if (g_up == G_FULL)  state_d = ST_ON;
                end
                ST_ON: begin
                    pop_req  = 1'b1;
                    sample_d = head;
                    g_d      = G_FULL;
                    if (mute) state_d = ST_RAMP_DOWN;
                end
                ST_RAMP_DOWN: begin
                    pop_req  = 1'b1;
                    sample_d = head;
                    g_d      = g_dn;
                    if (!mute)               state_d = ST_RAMP_UP;
                    else if (g_dn == 9'd0)   state_d = ST_OFF;
                end
`else
                ST_ON: begin
                    pop_req  = 1'b1;
                    sample_d = head;
                    if (mute) begin
                        state_d = ST_OFF;
                        g_d     = '0;
                    end
                end
`endif
                default: begin
                    state_d = ST_OFF;
                    g_d     = '0;
                end
            endcase
        end
    end

    // Underrun counter: saturating, clear wins over a same-cycle increment.
    always_comb begin
        under_d = under_q;
        if (pop_req && empty && under_q != 8'hFF) under_d = under_q + 8'd1;
        if (clr_underrun) under_d = '0;
    end

    // Gain multiply: signed 16x9 product, arithmetic shift by 8.
    always_comb begin
        product = $signed(24'(sample_q)) * $signed(24'(g_q));
        sig_d   = 16'(product >>> 8);
    end

    // Sample storage; no reset so it maps onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= s_data;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            state_q  <= ST_OFF;
            g_q      <= '0;
            sample_q <= '0;
            sig_q    <= '0;
            under_q  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            state_q  <= state_d;
            g_q      <= g_d;
            sample_q <= sample_d;
            sig_q    <= sig_d;
            under_q  <= under_d;
        end
    end

endmodule

// File: tb/tb_sddac_ctrl.sv
// Testbench for sddac_ctrl: table of multi-tick phases with fixed expected
// outputs, hand sequences for tick timing and asynchronous reset, and a
// randomized run, all cross-checked every cycle against a queue-based model.
module tb_sddac_ctrl;

    localparam int DIV   = 12;
    localparam int DEPTH = 4;
    localparam int STEP  = 4;
`ifdef SDDAC_CTRL_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif
    localparam int M_OFF = 0, M_UP = 1, M_ON = 2, M_DOWN = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        mute = 1'b1;
    logic        clr_underrun = 1'b0;
    logic        sample_tick;
    logic [15:0] sig_out;
    logic [7:0]  underrun_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sddac_ctrl #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH), .RAMP_STEP(STEP)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .mute(mute), .clr_underrun(clr_underrun),
        .sample_tick(sample_tick), .sig_out(sig_out), .underrun_cnt(underrun_cnt)
    );

    // Behavioural model state
    int m_ncyc, m_state, m_g, m_sample, m_sig, m_under;
    bit m_tick;
    int m_q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    task automatic model_reset();
        m_ncyc = 0; m_state = M_OFF; m_g = 0; m_sample = 0;
        m_sig = 0; m_under = 0; m_tick = 1'b0;
        m_q.delete();
    endtask

    // One clock edge of the controller, described from its rules.
    task automatic model_step();
        bit tick, push;
        tick = (m_ncyc % DIV) == DIV - 1;
        push = s_valid && (m_q.size() < DEPTH);
        m_sig = (m_sample * m_g) >>> 8;
        if (tick) begin
            if (m_state == M_OFF) begin
                m_sample = 0;
                if (!mute) begin
                    if (RAMP) m_state = M_UP;
                    else begin m_state = M_ON; m_g = 256; end
                end
            end else begin
                if (m_q.size() > 0) m_sample = m_q.pop_front();
                else begin
                    m_sample = 0;
                    if (m_under < 255) m_under++;
                end
                if (!RAMP) begin
                    if (mute) begin m_state = M_OFF; m_g = 0; end
                end else begin
                    case (m_state)
                        M_UP: begin
                            m_g = (m_g + STEP > 256) ? 256 : m_g + STEP;
                            if (mute) m_state = M_DOWN;
                            else if (m_g == 256) m_state = M_ON;
                        end
                        M_ON: begin
                            m_g = 256;
                            if (mute) m_state = M_DOWN;
                        end
                        M_DOWN: begin
                            m_g = (m_g < STEP) ? 0 : m_g - STEP;
                            if (!mute) m_state = M_UP;
                            else if (m_g == 0) m_state = M_OFF;
                        end
                        default: m_state = M_OFF;
                    endcase
                end
            end
        end
        if (clr_underrun) m_under = 0;
        if (push) m_q.push_back(int'($signed(s_data)));
        m_ncyc++;
        m_tick = (m_ncyc % DIV) == DIV - 1;
    endtask

    task automatic compare_model();
        chk("mdl_tick", sample_tick, m_tick);
        chk("mdl_ready", s_ready, m_q.size() < DEPTH);
        chk("mdl_sig", sig_out, m_sig[15:0]);
        chk("mdl_under", underrun_cnt, m_under[7:0]);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic run_ticks(input int n);
        int seen = 0;
        for (int i = 0; i < n * DIV + DIV && seen < n; i++) begin
            cycle();
            if (m_tick) seen++;
        end
    endtask

    typedef struct {
        logic        mute;
        logic        prod;
        logic        clr;
        logic [15:0] data;
        int          ticks;
        logic [15:0] sig_r;
        logic [15:0] sig_n;
        logic [7:0]  under;
        logic        ready;
    } vec_t;

    vec_t vt[18];

    initial begin
        // mute, prod, clr, data, ticks, sig(ramp), sig(no ramp), underruns, ready
        vt[0]  = '{1'b0, 1'b1, 1'b0, 16'h4000,   1, 16'h0000, 16'h0000, 8'd0,   1'b0};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 16'h4000,   1, 16'h0100, 16'h4000, 8'd0,   1'b0};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 16'h4000,  62, 16'h3F00, 16'h4000, 8'd0,   1'b0};
        vt[3]  = '{1'b0, 1'b1, 1'b0, 16'h4000,   1, 16'h4000, 16'h4000, 8'd0,   1'b0};
        vt[4]  = '{1'b0, 1'b1, 1'b0, 16'h4000,   5, 16'h4000, 16'h4000, 8'd0,   1'b0};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 16'h4000,   1, 16'h4000, 16'h0000, 8'd0,   1'b0};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 16'h4000,   1, 16'h3F00, 16'h0000, 8'd0,   1'b0};
        vt[7]  = '{1'b1, 1'b1, 1'b0, 16'h4000,  63, 16'h0000, 16'h0000, 8'd0,   1'b0};
        vt[8]  = '{1'b1, 1'b1, 1'b0, 16'h4000,   2, 16'h0000, 16'h0000, 8'd0,   1'b0};
        vt[9]  = '{1'b0, 1'b1, 1'b0, 16'h7FFF,  66, 16'h7FFF, 16'h7FFF, 8'd0,   1'b0};
        vt[10] = '{1'b0, 1'b0, 1'b0, 16'h7FFF,   4, 16'h7FFF, 16'h7FFF, 8'd0,   1'b1};
        vt[11] = '{1'b0, 1'b0, 1'b0, 16'h7FFF,   1, 16'h0000, 16'h0000, 8'd1,   1'b1};
        vt[12] = '{1'b0, 1'b0, 1'b0, 16'h7FFF, 299, 16'h0000, 16'h0000, 8'd255, 1'b1};
        vt[13] = '{1'b0, 1'b0, 1'b1, 16'h7FFF,   0, 16'h0000, 16'h0000, 8'd0,   1'b1};
        vt[14] = '{1'b0, 1'b1, 1'b0, 16'h8000,   5, 16'h8000, 16'h8000, 8'd0,   1'b0};
        vt[15] = '{1'b1, 1'b1, 1'b0, 16'h8000,  33, 16'hC000, 16'h0000, 8'd0,   1'b0};
        vt[16] = '{1'b1, 1'b1, 1'b0, 16'h8000,  32, 16'h0000, 16'h0000, 8'd0,   1'b0};
        vt[17] = '{1'b0, 1'b1, 1'b0, 16'h4000,  26, 16'h1900, 16'h4000, 8'd0,   1'b0};

        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset values, then first tick at count DIV-1 and period DIV.
        chk("rst_sig", sig_out, 16'h0000);
        chk("rst_ready", s_ready, 1'b1);
        chk("rst_tick", sample_tick, 1'b0);
        chk("rst_under", underrun_cnt, 8'd0);
        begin
            int c;
            c = 0;
            for (int i = 0; i < 3 * DIV; i++) begin
                cycle(); c++;
                if (sample_tick) break;
            end
            chk("first_tick_cycle", c, DIV - 1);
            c = 0;
            for (int i = 0; i < 3 * DIV; i++) begin
                cycle(); c++;
                if (sample_tick) break;
            end
            chk("tick_period", c, DIV);
            cycle();
        end

        // Table phases
        for (int i = 0; i < 18; i++) begin
            mute    = vt[i].mute;
            s_valid = vt[i].prod;
            s_data  = vt[i].data;
            if (vt[i].clr) begin
                clr_underrun = 1'b1;
                cycle();
                clr_underrun = 1'b0;
            end
            run_ticks(vt[i].ticks);
            cycle();
            cycle();
            chk($sformatf("vec%0d_sig", i), sig_out, RAMP ? vt[i].sig_r : vt[i].sig_n);
            chk($sformatf("vec%0d_under", i), underrun_cnt, vt[i].under);
            chk($sformatf("vec%0d_ready", i), s_ready, vt[i].ready);
        end

        // Asynchronous reset in the middle of a ramp (g=100 when ramp enabled).
        cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sig", sig_out, 16'h0000);
        chk("arst_ready", s_ready, 1'b1);
        chk("arst_tick", sample_tick, 1'b0);
        chk("arst_under", underrun_cnt, 8'd0);
        model_reset();
        cycle();
        cycle();
        rst_n = 1'b1;
        run_ticks(2);
        cycle();
        cycle();
        chk("restart_sig", sig_out, RAMP ? 16'h0100 : 16'h4000);

        // Randomized traffic with mute toggles and occasional clears.
        begin
            bit prod_on;
            prod_on = 1'b1;
            for (int i = 0; i < 150 * DIV; i++) begin
                if (m_tick) begin
                    if ($urandom_range(0, 5) == 0) mute = ~mute;
                    prod_on = ($urandom_range(0, 2) != 0);
                end
                s_valid      = prod_on && ($urandom_range(0, 3) != 0);
                s_data       = 16'($urandom);
                clr_underrun = ($urandom_range(0, 99) == 0);
                cycle();
            end
            clr_underrun = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
